// File: rtl/sd_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sd_loader_pkg
// Purpose  : Shared constants and FSM encoding for the SD image loader.
// Revision : 1.0
// ============================================================================
package sd_loader_pkg;

    localparam int BLOCKS_PER_IMG  = 600;
    localparam int BYTES_PER_BLOCK = 512;
    localparam int BLOCK_BITS      = 4096;
    localparam int FB_BYTES        = 307200;

    localparam int ID_W   = 10;
    localparam int BLK_W  = 10;
    localparam int BYTE_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_FIN     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sd_image_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_image_loader_if
// Purpose  : Control, SD-reader and frame-buffer signals of the image loader.
//            checksum exists only when SD_IMAGE_LOADER_CHECKSUM_EN is defined.
// Revision : 1.0
// ============================================================================
interface sd_image_loader_if #(
    parameter int ADDR_W = 19
);
    import sd_loader_pkg::*;

    logic                  start;
    logic [ID_W-1:0]       img_id;
    logic                  busy;
    logic                  done;
    logic [ID_W-1:0]       sd_img_id;
    logic [BLK_W-1:0]      sd_block_id;
    logic                  sd_r;
    logic                  sd_done;
    logic [BLOCK_BITS-1:0] sd_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_W-1:0]     wr_addr;
    logic [7:0]            wr_data;
`ifdef SD_IMAGE_LOADER_CHECKSUM_EN
    logic [15:0]           checksum;
`endif

    // master is the loader itself
    modport master (
        input  start, img_id, sd_done, sd_data, wr_ready,
        output busy, done, sd_img_id, sd_block_id, sd_r, wr_valid, wr_addr, wr_data
`ifdef SD_IMAGE_LOADER_CHECKSUM_EN
        , output checksum
`endif
    );

    modport slave (
        output start, img_id, sd_done, sd_data, wr_ready,
        input  busy, done, sd_img_id, sd_block_id, sd_r, wr_valid, wr_addr, wr_data
`ifdef SD_IMAGE_LOADER_CHECKSUM_EN
        , input checksum
`endif
    );

endinterface
`default_nettype wire

// File: rtl/block_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : block_unpacker
// Purpose  : Holds one SD block and emits it byte 0 first over valid/ready.
// Revision : 1.0
// ============================================================================
module block_unpacker
    import sd_loader_pkg::*;
(
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_load,
    input  wire logic [BLOCK_BITS-1:0] i_data,
    input  wire logic                  i_ready,
    output logic                       o_valid,
    output logic [7:0]                 o_data,
    output logic [BYTE_W-1:0]          o_byte_cnt,
    output logic                       o_last
);

    logic [BLOCK_BITS-1:0] r_buf;
    logic [BYTE_W-1:0]     r_cnt;
    logic                  r_valid;
    logic                  w_acc;

    assign w_acc      = r_valid & i_ready;
    assign o_last     = w_acc && (r_cnt == BYTE_W'(BYTES_PER_BLOCK - 1));
    assign o_valid    = r_valid;
    assign o_data     = r_buf[7:0];
    assign o_byte_cnt = r_cnt;

    // r_cnt wraps to 0 naturally on the last byte, ready for the next block
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_buf   <= i_data;
            r_cnt   <= '0;
            r_valid <= 1'b1;
        end else if (w_acc) begin
            r_buf <= r_buf >> 8;
            r_cnt <= r_cnt + 1'b1;
            if (o_last) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sd_image_loader.sv
`default_nettype none
// ============================================================================
// Module   : sd_image_loader
// Purpose  : Reads every block of one image from the SD reader and streams
//            its bytes into the frame buffer. Option: SD_IMAGE_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module sd_image_loader #(
    parameter int BLOCKS_PER_IMG  = 600,
    parameter int BYTES_PER_BLOCK = 512,
    parameter int ADDR_W          = 19
) (
    input  wire logic          CLOCK_50,
    input  wire logic          RESET,
    sd_image_loader_if.master  bus
);
    import sd_loader_pkg::*;

    localparam logic [BLK_W-1:0] c_LAST_BLK = BLK_W'(BLOCKS_PER_IMG - 1);

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_sd_r;
    logic [ID_W-1:0]   r_img;
    logic [BLK_W-1:0]  r_blk;

    logic              w_load;
    logic              w_valid;
    logic [7:0]        w_data;
    logic [BYTE_W-1:0] w_cnt;
    logic              w_last;

    assign w_load = (r_state == ST_REQ) && bus.sd_done;

    block_unpacker u_unpack (
        .clk        (CLOCK_50),
        .rst        (RESET),
        .i_load     (w_load),
        .i_data     (bus.sd_data),
        .i_ready    (bus.wr_ready),
        .o_valid    (w_valid),
        .o_data     (w_data),
        .o_byte_cnt (w_cnt),
        .o_last     (w_last)
    );

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.sd_r        = r_sd_r;
    assign bus.sd_img_id   = r_img;
    assign bus.sd_block_id = r_blk;
    assign bus.wr_valid    = w_valid;
    assign bus.wr_data     = w_data;
    assign bus.wr_addr     = ADDR_W'(r_blk) * ADDR_W'(BYTES_PER_BLOCK) + ADDR_W'(w_cnt);

    // The reader only clears done after r falls, so every new request waits for done==0
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sd_r  <= 1'b0;
            r_img   <= '0;
            r_blk   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_img  <= bus.img_id;
                        r_blk  <= '0;
                        r_busy <= 1'b1;
                        if (bus.sd_done) begin
                            r_state <= ST_RELEASE;
                        end else begin
                            r_sd_r  <= 1'b1;
                            r_state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.sd_done) begin
                        r_sd_r  <= 1'b0;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_last) begin
                        if (r_blk == c_LAST_BLK) begin
                            r_state <= ST_FIN;
                        end else begin
                            r_blk   <= r_blk + 1'b1;
                            r_state <= ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!bus.sd_done) begin
                        r_sd_r  <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_FIN: begin
                    if (!bus.sd_done) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SD_IMAGE_LOADER_CHECKSUM_EN
    logic [15:0] r_csum;

    assign bus.checksum = r_csum;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_csum <= '0;
        end else if ((r_state == ST_IDLE) && bus.start) begin
            r_csum <= '0;
        end else if (w_valid && bus.wr_ready) begin
            r_csum <= r_csum + {8'h00, w_data};
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sd_image_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_image_loader
// Purpose  : Randomized bench with SD reader model and frame-buffer scoreboard.
// Revision : 1.0
// ============================================================================
module tb_sd_image_loader;
    import sd_loader_pkg::*;

    localparam int NBLK   = 8;
    localparam int NBYTES = NBLK * 512;

    logic clk = 1'b0;
    logic RESET = 1'b1;
    always #5 clk = ~clk;

    sd_image_loader_if #(.ADDR_W(19)) bus ();

    sd_image_loader #(
        .BLOCKS_PER_IMG  (NBLK),
        .BYTES_PER_BLOCK (512),
        .ADDR_W          (19)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (RESET),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    int          cur_img   = 0;
    logic [31:0] cur_seed  = 0;
    bit          ones_mode = 0;
    int          rd_dly    = 20;
    int          rd_hold   = 0;
    int          stall_pct = 0;
    bit          mon_en    = 0;
    int          exp_addr  = 0;
    logic [15:0] csum_m    = 0;
    int          done_cnt  = 0;
    int          img_viol  = 0;
    int          hs_viol   = 0;
    int          blk_q[$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pixel value of image img, block b, byte k
    function automatic logic [7:0] pix(input int img, input int b, input int k);
        logic [31:0] h;
        if (ones_mode) return 8'h01;
        h = cur_seed + 32'(img) * 131 + 32'(b) * 997 + 32'(k) * 7;
        h = h * 32'h9E3779B1;
        return h[31:24];
    endfunction

    // SD reader: done rd_dly cycles after r, held rd_hold cycles after r falls
    initial begin
        int st = 0;
        int cnt = 0;
        int req_img = 0;
        int req_blk = 0;
        bus.sd_done = 1'b0;
        bus.sd_data = '0;
        forever begin
            @(negedge clk);
            case (st)
                0: if (bus.sd_r) begin
                    req_img = int'(bus.sd_img_id);
                    req_blk = int'(bus.sd_block_id);
                    blk_q.push_back(req_blk);
                    if (req_img != cur_img) img_viol++;
                    cnt = rd_dly;
                    st = 1;
                end
                1: begin
                    if (!bus.sd_r && !RESET) hs_viol++;
                    if (cnt > 1) cnt--;
                    else begin
                        for (int k = 0; k < 512; k++)
                            bus.sd_data[8*k +: 8] = pix(req_img, req_blk, k);
                        bus.sd_done = 1'b1;
                        st = 2;
                    end
                end
                2: if (!bus.sd_r) begin
                    if (rd_hold == 0) begin
                        bus.sd_done = 1'b0;
                        st = 0;
                    end else begin
                        cnt = rd_hold;
                        st = 3;
                    end
                end
                default: begin
                    if (bus.sd_r) hs_viol++;
                    if (cnt > 1) cnt--;
                    else begin
                        bus.sd_done = 1'b0;
                        st = 0;
                    end
                end
            endcase
        end
    end

    // Frame-buffer side: random wr_ready and byte scoreboard
    initial begin
        bit          prev_stall = 0;
        logic [18:0] pa = '0;
        logic [7:0]  pd = '0;
        logic [7:0]  ev;
        bus.wr_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done) done_cnt++;
            if (bus.busy && bus.sd_img_id != 10'(cur_img)) img_viol++;
            bus.wr_ready = ($urandom_range(99) >= stall_pct);
            if (mon_en) begin
                if (prev_stall) begin
                    check_eq("hold_valid", bus.wr_valid, 1);
                    check_eq("hold_addr", bus.wr_addr, pa);
                    check_eq("hold_data", bus.wr_data, pd);
                end
                if (bus.wr_valid && bus.wr_ready) begin
                    ev = pix(cur_img, exp_addr / 512, exp_addr % 512);
                    check_eq("wr_addr", bus.wr_addr, exp_addr);
                    check_eq("wr_data", bus.wr_data, ev);
                    csum_m = csum_m + {8'h00, ev};
                    exp_addr++;
                end
            end
            prev_stall = mon_en && bus.wr_valid && !bus.wr_ready;
            pa = bus.wr_addr;
            pd = bus.wr_data;
        end
    end

    task automatic do_start(input int img);
        @(negedge clk);
        bus.img_id = 10'(img);
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic begin_load(input int img, input bit ones);
        cur_img   = img;
        cur_seed  = $urandom;
        ones_mode = ones;
        exp_addr  = 0;
        csum_m    = '0;
        blk_q.delete();
        img_viol  = 0;
        hs_viol   = 0;
        mon_en    = 1;
        do_start(img);
        check_eq("busy_after_start", bus.busy, 1);
    endtask

    task automatic finish_load();
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < 40000) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_timeout", (done_cnt > d0), 1);
        repeat (6) @(negedge clk);
        check_eq("done_pulses", done_cnt - d0, 1);
        check_eq("bytes_written", exp_addr, NBYTES);
        check_eq("blk_requests", blk_q.size(), NBLK);
        for (int i = 0; i < blk_q.size() && i < NBLK; i++)
            check_eq("blk_seq", blk_q[i], i);
        check_eq("img_id_stable", img_viol, 0);
        check_eq("handshake", hs_viol, 0);
        check_eq("busy_end", bus.busy, 0);
`ifdef SD_IMAGE_LOADER_CHECKSUM_EN
        check_eq("checksum", bus.checksum, csum_m);
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_busy"}, bus.busy, 0);
        check_eq({tag, "_done"}, bus.done, 0);
        check_eq({tag, "_sd_r"}, bus.sd_r, 0);
        check_eq({tag, "_wr_valid"}, bus.wr_valid, 0);
        check_eq({tag, "_sd_img_id"}, bus.sd_img_id, 0);
        check_eq({tag, "_sd_block_id"}, bus.sd_block_id, 0);
        check_eq({tag, "_wr_addr"}, bus.wr_addr, 0);
        check_eq({tag, "_wr_data"}, bus.wr_data, 0);
`ifdef SD_IMAGE_LOADER_CHECKSUM_EN
        check_eq({tag, "_checksum"}, bus.checksum, 0);
`endif
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        bus.start  = 1'b0;
        bus.img_id = '0;
        RESET = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        RESET = 1'b0;
        @(negedge clk);

        // Image 3 with light stalls; a start for image 7 mid-load must be ignored
        stall_pct = 20; rd_dly = 20; rd_hold = 0;
        begin_load(3, 0);
        n = 0;
        while (bus.sd_block_id != 10'd3 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_blk3", bus.sd_block_id, 3);
        do_start(7);
        check_eq("img_after_restart", bus.sd_img_id, 3);
        finish_load();

        // Heavy backpressure, reader holds done 5 cycles after r falls
        stall_pct = 50; rd_hold = 5; rd_dly = $urandom_range(3, 25);
        begin_load(5, 0);
        finish_load();

        // Reset in the middle of block 5, byte 100
        stall_pct = 10; rd_hold = 0; rd_dly = 20;
        begin_load(9, 0);
        n = 0;
        while (!(bus.wr_valid && bus.wr_addr == 19'(5*512 + 100)) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq("reach_b5_k100", bus.wr_addr, 5*512 + 100);
        mon_en = 0;
        d0 = done_cnt;
        RESET = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        repeat (2) @(negedge clk);
        RESET = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("no_done_after_reset", done_cnt - d0, 0);

        stall_pct = 15; rd_hold = 3;
        begin_load(1, 0);
        finish_load();

        // All-0x01 image: checksum is the byte count mod 2^16
        stall_pct = 0; rd_hold = 2;
        begin_load(2, 1);
        finish_load();
`ifdef SD_IMAGE_LOADER_CHECKSUM_EN
        check_eq("checksum_ones", bus.checksum, 16'(NBYTES));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_image_loader.md
Name: sd_image_loader

Overview:
- Sequencer that sits directly upstream and downstream of the SD block reader.
- Drives the reader's request side: img_id, block_id and the r/done handshake.
- Walks every block of one image and unpacks each 4096-bit block into bytes.
- Streams the bytes with addresses into the frame-buffer write port; one byte per pixel, 640x480 = 307200 bytes = 600 blocks.

Parameters:
- BLOCKS_PER_IMG, 600, blocks per image.
- BYTES_PER_BLOCK, 512, bytes per SD block; the reader delivers 4096 bits.
- ADDR_W, 19, frame-buffer byte-address width.

Ports:
- CLOCK_50  in  1  sole clock, rising edge.
- RESET  in  1  reset; synchronous, active-high.
- start  in  1  1-cycle request to load image; ignored unless idle.
- img_id  in  10  image index, sampled when start is accepted.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  1-cycle pulse when the whole image has been written.
- sd_img_id  out  10  to reader img_id; latched copy.
- sd_block_id  out  10  to reader block_id.
- sd_r  out  1  to reader r; read request.
- sd_done  in  1  from reader done.
- sd_data  in  4096  from reader data; byte k is at [8k+7:8k], and byte 0 is the first byte on the card.
- wr_valid  out  1  byte available.
- wr_ready  in  1  frame buffer accepts the byte.
- wr_addr  out  ADDR_W  byte address, equal to block*512+byte.
- wr_data  out  8  pixel byte.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the internal buffer and counters clear. Reset mid-operation drops sd_r in the following cycle and abandons the load; no done pulse is produced.
- FSM states: IDLE, REQ, DRAIN, RELEASE, FIN.
- IDLE: on start=1, latch img_id into sd_img_id, set sd_block_id=0, byte_cnt=0, busy=1, go to REQ.
  - If sd_done is still 1 from an earlier read, go to RELEASE first.
- REQ: sd_r=1 and hold until sd_done=1.
  - In that cycle: capture sd_data into a 4096-bit buffer, set sd_r<=0, go to DRAIN.
  - sd_block_id and sd_img_id stay stable for the whole time sd_r is high.
- DRAIN: wr_valid=1, wr_data=buf[7:0], wr_addr=sd_block_id*512+byte_cnt.
  - On wr_valid&&wr_ready: shift buf right by 8 and increment byte_cnt.
  - If not accepted, wr_data and wr_addr hold stable and wr_valid stays high.
  - wr_valid drops in the cycle after byte 511 is accepted; no bubble between accepted bytes.
  - After byte 511 is accepted, set byte_cnt=0:
    - if sd_block_id==BLOCKS_PER_IMG-1, go to FIN;
    - otherwise increment sd_block_id and go to RELEASE.
- RELEASE: sd_r=0; wait for sd_done==0, because the reader only clears done after r falls; then go to REQ. If sd_done is already 0, leave the next cycle.
- FIN: wait for sd_done==0, then done=1 for one cycle, busy=0, go to IDLE.
- start while busy is ignored. img_id changes while busy have no effect.
- Counters: byte_cnt is 9 bits and wraps at 512; the block counter stops at 599 and never wraps. Address arithmetic is done at ADDR_W bits, giving a maximum wr_addr of 307199.
- Latency: REQ to first wr_valid is one cycle after sd_done is seen. A full image with wr_ready always high takes about 600*(512+3) cycles plus the reader's time.

Optional Feature:
- Macro: SD_IMAGE_LOADER_CHECKSUM_EN.
- With it defined:
  - Add output checksum[15:0]: the mod-2^16 sum of every accepted wr_data byte.
  - It clears when start is accepted, and is valid and held from the done pulse until the next accepted start. Reset value is 0.
- Without it: no checksum port and no accumulator logic.

Decomposition:
- Shared package sd_loader_pkg:
  - state enum (IDLE, REQ, DRAIN, RELEASE, FIN);
  - constants BLOCKS_PER_IMG=600, BYTES_PER_BLOCK=512, BLOCK_BITS=4096, FB_BYTES=307200.
- Sub-module block_unpacker:
  - contains the 4096-bit load/shift buffer, the 9-bit byte counter, the valid/ready handshake and a last-byte flag;
  - the parent keeps the FSM, block counter and the reader handshake.

Test Plan:
- Load image: start with img_id=3, behavioural reader model with done 20 cycles after r, wr_ready=1 -> 307200 writes at addresses 0..307199. Block b byte k must equal f(3,b,k). Exactly one done pulse; sd_block_id sequence 0..599.
- Backpressure: wr_ready toggling 1/0 with random stalls during block 0 -> wr_addr/wr_data held while stalled; no byte lost or duplicated; byte order is data[7:0] first.
- Reader done handshake: model holds done high 5 cycles after r falls -> sd_r is not reasserted until done is 0; no double capture of the same block.
- start while busy: at block 10, pulse start with img_id=7 -> ignored; sd_img_id stays 3 to the end.
- Reset mid-DRAIN: RESET at block 42, byte 100 -> next cycle all outputs are 0 and the FSM is in IDLE. A following start with img_id=1 loads the whole image correctly from block 0.
- CHECKSUM_EN: all-0x01 image data -> checksum = 307200 mod 65536 = 0xB000 at the done pulse.
